// File: rtl/msf_pkg.sv
// Shared types and constants for the MSF minute-frame decoder.
// Bit offsets index the shift registers from the frame end (index 0 = second 59).
package msf_pkg;

    typedef enum logic {SEARCH, RECEIVE} msf_state_e;

    localparam logic [7:0] MARKER_PATTERN = 8'b0111_1110;

    localparam int unsigned SRA_W = 43;
    localparam int unsigned SRB_W = 8;

    localparam int unsigned YEAR_LSB   = 35;
    localparam int unsigned MONTH_LSB  = 30;
    localparam int unsigned DAY_LSB    = 24;
    localparam int unsigned DOW_LSB    = 21;
    localparam int unsigned HOUR_LSB   = 15;
    localparam int unsigned MINUTE_LSB = 8;

    localparam int unsigned PAR_YEAR = 5;
    localparam int unsigned PAR_DATE = 4;
    localparam int unsigned PAR_DOW  = 3;
    localparam int unsigned PAR_TIME = 2;

    localparam logic [5:0] MIN_FRAME_BITS = 6'd58;
    localparam logic [5:0] MAX_FRAME_BITS = 6'd60;

    typedef struct packed {
        logic [7:0] year;
        logic [4:0] month;
        logic [5:0] day;
        logic [5:0] hour;
        logic [6:0] minute;
    } msf_time_t;

    function automatic logic bcd_ok(input logic [3:0] n);
        return n <= 4'd9;
    endfunction

endpackage

// File: rtl/msf_frame_decoder_if.sv
// Symbol input and counter-load bus of the MSF decoder.
// master = decoder (load producer), slave = symbol source / counter chain.
interface msf_frame_decoder_if;
    logic       sec_strobe_i;
    logic       marker_i;
    logic       bit_a_i;
    logic       bit_b_i;
    logic       load_o;
    logic [3:0] year_h_o;
    logic [3:0] year_l_o;
    logic       month_h_o;
    logic [3:0] month_l_o;
    logic [1:0] day_h_o;
    logic [3:0] day_l_o;
    logic [1:0] hour_h_o;
    logic [3:0] hour_l_o;
    logic [2:0] minute_h_o;
    logic [3:0] minute_l_o;
    logic [2:0] second_h_o;
    logic [3:0] second_l_o;
    logic       locked_o;
    logic       frame_err_o;

    modport master (
        input  sec_strobe_i, marker_i, bit_a_i, bit_b_i,
        output load_o, year_h_o, year_l_o, month_h_o, month_l_o, day_h_o, day_l_o,
               hour_h_o, hour_l_o, minute_h_o, minute_l_o, second_h_o, second_l_o,
               locked_o, frame_err_o
    );

    modport slave (
        output sec_strobe_i, marker_i, bit_a_i, bit_b_i,
        input  load_o, year_h_o, year_l_o, month_h_o, month_l_o, day_h_o, day_l_o,
               hour_h_o, hour_l_o, minute_h_o, minute_l_o, second_h_o, second_l_o,
               locked_o, frame_err_o
    );
endinterface

// File: rtl/msf_field_check.sv
// Combinational marker, BCD range and (with MSF_PARITY_EN) odd-parity check
// over the frame shift registers; also unpacks the time fields.
module msf_field_check
    import msf_pkg::*;
(
    input  logic [SRA_W-1:0] sra,
    input  logic [SRB_W-1:0] srb,
    output msf_time_t        time_o,
    output logic             fields_ok
);

    msf_time_t t;
    logic      range_ok;
    logic      marker_ok;
    logic      parity_ok;
    logic      unused_b;

    always_comb begin
        t.year   = sra[YEAR_LSB   +: 8];
        t.month  = sra[MONTH_LSB  +: 5];
        t.day    = sra[DAY_LSB    +: 6];
        t.hour   = sra[HOUR_LSB   +: 6];
        t.minute = sra[MINUTE_LSB +: 7];

        marker_ok = (sra[7:0] == MARKER_PATTERN);

        range_ok = bcd_ok(t.year[7:4]) && bcd_ok(t.year[3:0])
                && bcd_ok(t.month[3:0])
                && (t.month[4] ? (t.month[3:0] <= 4'd2) : (t.month[3:0] != 4'd0))
                && bcd_ok(t.day[3:0]) && (t.day != 6'd0)
                && !((t.day[5:4] == 2'd3) && (t.day[3:0] > 4'd1))
                && bcd_ok(t.hour[3:0]) && (t.hour[5:4] != 2'd3)
                && !((t.hour[5:4] == 2'd2) && (t.hour[3:0] > 4'd3))
                && (t.minute[6:4] <= 3'd5) && bcd_ok(t.minute[3:0]);
    end

`ifdef MSF_PARITY_EN
    assign parity_ok = (^{sra[YEAR_LSB   +: 8],  srb[PAR_YEAR]})
                     & (^{sra[DAY_LSB    +: 11], srb[PAR_DATE]})
                     & (^{sra[DOW_LSB    +: 3],  srb[PAR_DOW]})
                     & (^{sra[MINUTE_LSB +: 13], srb[PAR_TIME]});
    assign unused_b  = ^{srb[7:6], srb[1:0]};
`else
    assign parity_ok = 1'b1;
    assign unused_b  = ^{srb, sra[DOW_LSB +: 3]};
`endif

    assign time_o    = t;
    assign fields_ok = marker_ok && range_ok && parity_ok;

endmodule

// File: rtl/msf_frame_decoder.sv
// MSF minute-frame assembler: validates each frame at the minute marker and
// pulses load with the BCD time starting at that marker. Option: MSF_PARITY_EN.
module msf_frame_decoder
    import msf_pkg::*;
#(
    parameter int unsigned CONFIRM_FRAMES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    msf_frame_decoder_if.master  bus
);

    localparam int unsigned      CONF_W   = $clog2(CONFIRM_FRAMES + 1);
    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM_FRAMES);

    msf_state_e        state;
    logic [5:0]        bit_cnt;
    logic [SRA_W-1:0]  sra;
    logic [SRB_W-1:0]  srb;
    logic [CONF_W-1:0] conf;
    logic [CONF_W-1:0] conf_inc;
    msf_time_t         time_q;
    msf_time_t         time_d;
    logic              fields_ok;
    logic              frame_ok;
    logic              load_q;
    logic              err_q;
    logic              locked_q;

    msf_field_check u_check (
        .sra       (sra),
        .srb       (srb),
        .time_o    (time_d),
        .fields_ok (fields_ok)
    );

    always_comb begin
        frame_ok = fields_ok && (bit_cnt >= MIN_FRAME_BITS) && (bit_cnt <= MAX_FRAME_BITS);
        conf_inc = (conf >= CONF_MAX) ? CONF_MAX : conf + CONF_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= SEARCH;
            bit_cnt  <= '0;
            sra      <= '0;
            srb      <= '0;
            conf     <= '0;
            time_q   <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            load_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.sec_strobe_i) begin
                case (state)
                    SEARCH: begin
                        if (bus.marker_i) begin
                            state   <= RECEIVE;
                            bit_cnt <= '0;
                        end
                    end
                    RECEIVE: begin
                        if (bus.marker_i) begin
                            bit_cnt <= '0;
                            if (frame_ok) begin
                                conf     <= conf_inc;
                                locked_q <= (conf_inc == CONF_MAX);
                                if (conf_inc == CONF_MAX) begin
                                    load_q <= 1'b1;
                                    time_q <= time_d;
                                end
                            end else begin
                                err_q    <= 1'b1;
                                conf     <= '0;
                                locked_q <= 1'b0;
                            end
                        end else begin
                            sra     <= {sra[SRA_W-2:0], bus.bit_a_i};
                            srb     <= {srb[SRB_W-2:0], bus.bit_b_i};
                            bit_cnt <= (bit_cnt == 6'h3F) ? bit_cnt : bit_cnt + 6'd1;
                            // 61st data bit without a marker: the frame is lost
                            if (bit_cnt == MAX_FRAME_BITS) begin
                                state    <= SEARCH;
                                err_q    <= 1'b1;
                                conf     <= '0;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign bus.load_o      = load_q;
    assign bus.frame_err_o = err_q;
    assign bus.locked_o    = locked_q;
    assign bus.year_h_o    = time_q.year[7:4];
    assign bus.year_l_o    = time_q.year[3:0];
    assign bus.month_h_o   = time_q.month[4];
    assign bus.month_l_o   = time_q.month[3:0];
    assign bus.day_h_o     = time_q.day[5:4];
    assign bus.day_l_o     = time_q.day[3:0];
    assign bus.hour_h_o    = time_q.hour[5:4];
    assign bus.hour_l_o    = time_q.hour[3:0];
    assign bus.minute_h_o  = time_q.minute[6:4];
    assign bus.minute_l_o  = time_q.minute[3:0];
    assign bus.second_h_o  = '0;
    assign bus.second_l_o  = '0;

endmodule

// File: tb/tb_msf_frame_decoder.sv
// Directed bench for msf_frame_decoder: one DUT with CONFIRM_FRAMES=1 and one
// with CONFIRM_FRAMES=2 share the same symbol stream.
module tb_msf_frame_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic strobe = 1'b0;
    logic marker = 1'b0;
    logic bit_a = 1'b0;
    logic bit_b = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // {load, err, load one cycle later, err one cycle later, locked}
    logic [4:0] obs1, obs2;
    logic [38:0] f1, f2;

    localparam logic [38:0] T_A = {8'h23, 5'h06, 6'h15, 6'h14, 7'h37, 7'h00};
    localparam logic [38:0] T_B = {8'h23, 5'h12, 6'h31, 6'h23, 7'h59, 7'h00};
    localparam logic [38:0] T_C = {8'h24, 5'h02, 6'h29, 6'h08, 7'h05, 7'h00};
    localparam logic [4:0] R_LOAD = 5'b10001;
    localparam logic [4:0] R_ERR  = 5'b01000;
    localparam logic [4:0] R_NONE = 5'b00000;

    always #5 clk = ~clk;

    msf_frame_decoder_if if1 ();
    msf_frame_decoder_if if2 ();

    assign if1.sec_strobe_i = strobe;
    assign if1.marker_i     = marker;
    assign if1.bit_a_i      = bit_a;
    assign if1.bit_b_i      = bit_b;
    assign if2.sec_strobe_i = strobe;
    assign if2.marker_i     = marker;
    assign if2.bit_a_i      = bit_a;
    assign if2.bit_b_i      = bit_b;

    assign f1 = {if1.year_h_o, if1.year_l_o, if1.month_h_o, if1.month_l_o, if1.day_h_o,
                 if1.day_l_o, if1.hour_h_o, if1.hour_l_o, if1.minute_h_o, if1.minute_l_o,
                 if1.second_h_o, if1.second_l_o};
    assign f2 = {if2.year_h_o, if2.year_l_o, if2.month_h_o, if2.month_l_o, if2.day_h_o,
                 if2.day_l_o, if2.hour_h_o, if2.hour_l_o, if2.minute_h_o, if2.minute_l_o,
                 if2.second_h_o, if2.second_l_o};

    msf_frame_decoder #(.CONFIRM_FRAMES(1)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
    msf_frame_decoder #(.CONFIRM_FRAMES(2)) u_dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));

    always @(negedge clk) begin
        if ((if1.load_o && if1.frame_err_o) || (if2.load_o && if2.frame_err_o)) begin
            miscompares++;
            $display("FAIL load_err_exclusive: load and frame_err both high at %0t", $time);
        end
    end

    // {A bits s17..s59, B bits s52..s59} with correct odd parity in 54B-57B
    function automatic logic [50:0] mk(input logic [7:0] y, input logic [4:0] mo,
                                       input logic [5:0] d, input logic [2:0] w,
                                       input logic [5:0] h, input logic [6:0] mi);
        logic [42:0] a;
        logic [7:0]  b;
        a = {y, mo, d, w, h, mi, 8'b0111_1110};
        b = {2'b00, ~^y, ~^{mo, d}, ~^w, ~^{h, mi}, 2'b00};
        return {a, b};
    endfunction

    task automatic sym(input logic mk_in, input logic a, input logic bb);
        logic l1, e1, k1, l2, e2, k2;
        @(negedge clk);
        strobe = 1'b1; marker = mk_in; bit_a = a; bit_b = bb;
        @(negedge clk);
        strobe = 1'b0; marker = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
        l1 = if1.load_o; e1 = if1.frame_err_o; k1 = if1.locked_o;
        l2 = if2.load_o; e2 = if2.frame_err_o; k2 = if2.locked_o;
        @(negedge clk);
        obs1 = {l1, e1, if1.load_o, if1.frame_err_o, k1};
        obs2 = {l2, e2, if2.load_o, if2.frame_err_o, k2};
        @(negedge clk);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) sym(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [50:0] t, input int lead);
        logic [42:0] ta;
        logic [7:0]  tb;
        ta = t[50:8];
        tb = t[7:0];
        send_zeros(lead);
        for (int i = 42; i >= 0; i--) sym(1'b0, ta[i], (i < 8) ? tb[i] : 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 2;
        if ({if1.load_o, if1.frame_err_o, if1.locked_o, f1} !== 42'd0) begin
            miscompares++; $display("FAIL reset_dut1: got %h want 0", {if1.load_o, if1.frame_err_o, if1.locked_o, f1});
        end
        if ({if2.load_o, if2.frame_err_o, if2.locked_o, f2} !== 42'd0) begin
            miscompares++; $display("FAIL reset_dut2: got %h want 0", {if2.load_o, if2.frame_err_o, if2.locked_o, f2});
        end
        rst_n = 1'b1;
        sym(1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs1 !== R_NONE) begin
            miscompares++; $display("FAIL first_marker: got %b want %b", obs1, R_NONE);
        end
    endtask

    task automatic test_basic;
        send_frame(mk(8'h23, 5'h06, 6'h15, 3'd1, 6'h14, 7'h37), 16);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs1 !== R_LOAD) begin
            miscompares++; $display("FAIL basic_strobes: got %b want %b", obs1, R_LOAD);
        end
        if (f1 !== T_A) begin
            miscompares++; $display("FAIL basic_fields: got %h want %h", f1, T_A);
        end
    endtask

    task automatic test_parity;
        logic [50:0] t;
        t = mk(8'h23, 5'h06, 6'h15, 3'd1, 6'h14, 7'h37);
        t[2] = ~t[2];
        send_frame(t, 16);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
`ifdef MSF_PARITY_EN
        if (obs1 !== R_ERR) begin
            miscompares++; $display("FAIL parity_reject: got %b want %b", obs1, R_ERR);
        end
`else
        if (obs1 !== R_LOAD) begin
            miscompares++; $display("FAIL parity_ignored: got %b want %b", obs1, R_LOAD);
        end
`endif
        if (f1 !== T_A) begin
            miscompares++; $display("FAIL parity_fields: got %h want %h", f1, T_A);
        end
    endtask

    task automatic test_leap;
        send_frame(mk(8'h23, 5'h12, 6'h31, 3'd0, 6'h23, 7'h59), 17);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs1 !== R_LOAD) begin
            miscompares++; $display("FAIL leap60_strobes: got %b want %b", obs1, R_LOAD);
        end
        if (f1 !== T_B) begin
            miscompares++; $display("FAIL leap60_fields: got %h want %h", f1, T_B);
        end
        send_frame(mk(8'h24, 5'h02, 6'h29, 3'd4, 6'h08, 7'h05), 15);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs1 !== R_LOAD) begin
            miscompares++; $display("FAIL leap58_strobes: got %b want %b", obs1, R_LOAD);
        end
        if (f1 !== T_C) begin
            miscompares++; $display("FAIL leap58_fields: got %h want %h", f1, T_C);
        end
    endtask

    task automatic test_short;
        send_zeros(30);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs1 !== R_ERR) begin
            miscompares++; $display("FAIL short_err: got %b want %b", obs1, R_ERR);
        end
        if (f1 !== T_C) begin
            miscompares++; $display("FAIL short_hold: got %h want %h", f1, T_C);
        end
        send_frame(mk(8'h23, 5'h06, 6'h15, 3'd1, 6'h14, 7'h37), 16);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs1 !== R_LOAD) begin
            miscompares++; $display("FAIL after_short_strobes: got %b want %b", obs1, R_LOAD);
        end
        if (f1 !== T_A) begin
            miscompares++; $display("FAIL after_short_fields: got %h want %h", f1, T_A);
        end
    endtask

    task automatic test_range;
        logic [50:0] t;
        send_frame(mk(8'h23, 5'h13, 6'h15, 3'd1, 6'h14, 7'h37), 16);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs1 !== R_ERR) begin
            miscompares++; $display("FAIL month13_err: got %b want %b", obs1, R_ERR);
        end
        if (f1 !== T_A) begin
            miscompares++; $display("FAIL month13_hold: got %h want %h", f1, T_A);
        end
        send_frame(mk(8'h23, 5'h06, 6'h15, 3'd1, 6'h14, 7'h5A), 16);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs1 !== R_ERR) begin
            miscompares++; $display("FAIL minute5A_err: got %b want %b", obs1, R_ERR);
        end
        if (f1 !== T_A) begin
            miscompares++; $display("FAIL minute5A_hold: got %h want %h", f1, T_A);
        end
        t = mk(8'h23, 5'h12, 6'h31, 3'd0, 6'h23, 7'h59);
        t[8] = 1'b1;
        send_frame(t, 16);
        sym(1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs1 !== R_ERR) begin
            miscompares++; $display("FAIL bad_marker_err: got %b want %b", obs1, R_ERR);
        end
    endtask

    task automatic test_overflow;
        send_zeros(60);
        vectors++;
        if (obs1 !== R_NONE) begin
            miscompares++; $display("FAIL bit60_quiet: got %b want %b", obs1, R_NONE);
        end
        send_zeros(1);
        vectors++;
        if (obs1 !== R_ERR) begin
            miscompares++; $display("FAIL bit61_err: got %b want %b", obs1, R_ERR);
        end
        sym(1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs1 !== R_NONE) begin
            miscompares++; $display("FAIL resync_marker: got %b want %b", obs1, R_NONE);
        end
        send_frame(mk(8'h23, 5'h12, 6'h31, 3'd0, 6'h23, 7'h59), 16);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs1 !== R_LOAD) begin
            miscompares++; $display("FAIL resync_load: got %b want %b", obs1, R_LOAD);
        end
        if (f1 !== T_B) begin
            miscompares++; $display("FAIL resync_fields: got %h want %h", f1, T_B);
        end
    endtask

    task automatic test_confirm;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sym(1'b1, 1'b0, 1'b0);
        send_frame(mk(8'h23, 5'h06, 6'h15, 3'd1, 6'h14, 7'h37), 16);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 3;
        if (obs1 !== R_LOAD) begin
            miscompares++; $display("FAIL conf1_dut1: got %b want %b", obs1, R_LOAD);
        end
        if (obs2 !== R_NONE) begin
            miscompares++; $display("FAIL conf2_first: got %b want %b", obs2, R_NONE);
        end
        if (f2 !== 39'd0) begin
            miscompares++; $display("FAIL conf2_first_fields: got %h want 0", f2);
        end
        send_frame(mk(8'h23, 5'h12, 6'h31, 3'd0, 6'h23, 7'h59), 16);
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs2 !== R_LOAD) begin
            miscompares++; $display("FAIL conf2_second: got %b want %b", obs2, R_LOAD);
        end
        if (f2 !== T_B) begin
            miscompares++; $display("FAIL conf2_fields: got %h want %h", f2, T_B);
        end
        send_zeros(20);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors += 2;
        if ({if1.load_o, if1.frame_err_o, if1.locked_o, f1} !== 42'd0) begin
            miscompares++; $display("FAIL midreset_dut1: got %h want 0", {if1.load_o, if1.frame_err_o, if1.locked_o, f1});
        end
        if ({if2.load_o, if2.frame_err_o, if2.locked_o, f2} !== 42'd0) begin
            miscompares++; $display("FAIL midreset_dut2: got %h want 0", {if2.load_o, if2.frame_err_o, if2.locked_o, f2});
        end
        rst_n = 1'b1;
        sym(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (obs1 !== R_NONE) begin
            miscompares++; $display("FAIL post_reset_marker_dut1: got %b want %b", obs1, R_NONE);
        end
        if (obs2 !== R_NONE) begin
            miscompares++; $display("FAIL post_reset_marker_dut2: got %b want %b", obs2, R_NONE);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_leap();
        test_short();
        test_range();
        test_overflow();
        test_confirm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
